// File: rtl/jesd204_rx_fec_sh_extract.sv
// JESD204C RX sync-header extractor: gathers the 32 SH bits of a multiblock, checks separator/pilot,
// runs a HUNT/LOCK FSM and hands the FEC word to the decoder. Option macro: JESD204_FEC_SH_STATS_EN.
module jesd204_rx_fec_sh_extract #(
   parameter int LOCK_COUNT    = 4,
   parameter int UNLOCK_COUNT  = 2,
   parameter int ERR_CNT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     header_valid,
   input  logic [1:0]               header,
   input  logic                     eomb,
   output logic [25:0]              fec_out,
   output logic                     fec_out_valid,
   output logic                     lock,
   output logic                     header_err,
   output logic [ERR_CNT_WIDTH-1:0] pilot_err_cnt
);
   localparam int GW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
   localparam int BW = (UNLOCK_COUNT > 1) ? $clog2(UNLOCK_COUNT) : 1;
   localparam logic [GW-1:0] G_LAST = GW'(LOCK_COUNT - 1);
   localparam logic [BW-1:0] B_LAST = BW'(UNLOCK_COUNT - 1);

   typedef enum logic {ST_HUNT, ST_LOCK} state_t;

   state_t         state_q;
   logic [GW-1:0]  gcnt_q;
   logic [BW-1:0]  bcnt_q;
   logic [30:0]    sh_q;
   logic [4:0]     cnt_q;
   logic           overrun_q;
   logic           inv_q;
   logic           header_err_q;
   logic [25:0]    fec_q;
   logic           fec_valid_q;

   logic           sh_bit;
   logic           hdr_inv;
   logic           eval;
   logic           good;
   logic [31:0]    mb_bits;

   // The closing block's bit is evaluated combinationally, so 31 stored bits complete the 32-bit word.
   always_comb begin
      sh_bit  = (header == 2'b10);
      hdr_inv = (header == 2'b00) || (header == 2'b11);
      mb_bits = {sh_q, sh_bit};
      eval    = header_valid & eomb;
      good    = (cnt_q == 5'd31) & ~overrun_q & ~inv_q & ~hdr_inv & mb_bits[5] &
                (mb_bits[4:0] == 5'b00001);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sh_q         <= '0;
         cnt_q        <= '0;
         overrun_q    <= 1'b0;
         inv_q        <= 1'b0;
         header_err_q <= 1'b0;
      end else begin
         header_err_q <= header_valid & hdr_inv;
         if (header_valid) begin
            sh_q <= mb_bits[30:0];
            if (eomb) begin
               cnt_q     <= '0;
               overrun_q <= 1'b0;
               inv_q     <= 1'b0;
            end else begin
               if (cnt_q == 5'd31) begin
                  overrun_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 5'd1;
               end
               if (hdr_inv) begin
                  inv_q <= 1'b1;
               end
            end
         end
      end
   end

   // Lock FSM; fec_out_valid is asserted only when the post-update state is LOCK.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_HUNT;
         gcnt_q      <= '0;
         bcnt_q      <= '0;
         fec_q       <= '0;
         fec_valid_q <= 1'b0;
      end else begin
         fec_valid_q <= 1'b0;
         if (eval) begin
            if (good) begin
               fec_q <= mb_bits[31:6];
            end
            case (state_q)
               ST_HUNT: begin
                  if (!good) begin
                     gcnt_q <= '0;
                  end else if (gcnt_q == G_LAST) begin
                     state_q     <= ST_LOCK;
                     gcnt_q      <= '0;
                     fec_valid_q <= 1'b1;
                  end else begin
                     gcnt_q <= gcnt_q + 1'b1;
                  end
               end
               ST_LOCK: begin
                  if (good) begin
                     bcnt_q      <= '0;
                     fec_valid_q <= 1'b1;
                  end else if (bcnt_q == B_LAST) begin
                     state_q <= ST_HUNT;
                     bcnt_q  <= '0;
                  end else begin
                     bcnt_q <= bcnt_q + 1'b1;
                  end
               end
               default: state_q <= ST_HUNT;
            endcase
         end
      end
   end

`ifdef JESD204_FEC_SH_STATS_EN
   logic [ERR_CNT_WIDTH-1:0] err_cnt_q;
   logic [ERR_CNT_WIDTH-1:0] err_cnt_d;

   // Counted against the pre-update state, so the multiblock that drops lock is still counted.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (eval && !good && (state_q == ST_LOCK) && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign pilot_err_cnt = err_cnt_q;
`else
   assign pilot_err_cnt = '0;
`endif

   assign fec_out       = fec_q;
   assign fec_out_valid = fec_valid_q;
   assign lock          = (state_q == ST_LOCK);
   assign header_err    = header_err_q;

endmodule

// File: tb/tb_jesd204_rx_fec_sh_extract.sv
// Directed bench for jesd204_rx_fec_sh_extract: multiblock expectations are queued when driven and
// popped one cycle after the closing eomb block.
module tb_jesd204_rx_fec_sh_extract;
   logic        clk = 1'b0;
   logic        resetn;
   logic        header_valid;
   logic [1:0]  header;
   logic        eomb;
   logic [25:0] fec_out;
   logic        fec_out_valid;
   logic        lock;
   logic        header_err;
   logic [15:0] pilot_err_cnt;

   int n_assert = 0;
   int n_fail   = 0;
   int v_pulses = 0;
   int e_pulses = 0;
   int exp_v_pulses = 0;
   int exp_e_pulses = 0;

   localparam logic [5:0]  TAIL_OK    = 6'b100001;
   localparam logic [5:0]  TAIL_PILOT = 6'b100011;
   localparam logic [25:0] FA = 26'h15A5A5A;
   localparam logic [25:0] FB = 26'h2C3F00D;
   localparam logic [25:0] FC = 26'h0F0F0F1;
   localparam logic [25:0] FD = 26'h1234567;
   localparam logic [25:0] FE = 26'h3A5C0E7;

   typedef struct {
      logic        v;
      logic        l;
      logic [25:0] f;
      logic [15:0] e;
   } exp_t;
   exp_t sbq[$];

   always #5 clk = ~clk;

   jesd204_rx_fec_sh_extract #(
      .LOCK_COUNT   (4),
      .UNLOCK_COUNT (2),
      .ERR_CNT_WIDTH(16)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .header_valid (header_valid),
      .header       (header),
      .eomb         (eomb),
      .fec_out      (fec_out),
      .fec_out_valid(fec_out_valid),
      .lock         (lock),
      .header_err   (header_err),
      .pilot_err_cnt(pilot_err_cnt)
   );

   always @(negedge clk) begin
      if (fec_out_valid) v_pulses <= v_pulses + 1;
      if (header_err)    e_pulses <= e_pulses + 1;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time expired, required $finish before 300000");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] xerr(input int n);
`ifdef JESD204_FEC_SH_STATS_EN
      return 16'(n);
`else
      return 16'(n * 0);
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic blk(input logic [1:0] h, input logic e);
      @(negedge clk);
      header_valid = 1'b1;
      header       = h;
      eomb         = e;
      @(posedge clk);
      #1;
      header_valid = 1'b0;
      eomb         = 1'b0;
   endtask

   task automatic send_mb(input string tag, input logic [25:0] fec, input logic [5:0] tail,
                          input int len, input int inv_k, input int gap,
                          input logic xv, input logic xl, input logic [25:0] xf, input logic [15:0] xe);
      logic [31:0] bits;
      logic [1:0]  h;
      exp_t        x;
      bits = {fec, tail};
      x.v = xv; x.l = xl; x.f = xf; x.e = xe;
      sbq.push_back(x);
      if (xv) exp_v_pulses++;
      for (int k = 0; k < len; k++) begin
         if (k == inv_k)                    h = 2'b11;
         else if (k < 32 && bits[31 - k])  h = 2'b10;
         else                               h = 2'b01;
         blk(h, k == len - 1);
         if (k == inv_k) begin
            exp_e_pulses++;
            chk({tag, ".header_err"}, 32'(header_err), 32'd1);
         end
         if (k == len - 1) begin
            x = sbq.pop_front();
            chk({tag, ".fec_out_valid"}, 32'(fec_out_valid), 32'(x.v));
            chk({tag, ".lock"},          32'(lock),          32'(x.l));
            chk({tag, ".fec_out"},       32'(fec_out),       32'(x.f));
            chk({tag, ".pilot_err_cnt"}, 32'(pilot_err_cnt), 32'(x.e));
         end
         repeat (gap) @(negedge clk);
      end
   endtask

   initial begin
      logic [31:0] ebits;
      header_valid = 1'b0;
      header       = 2'b00;
      eomb         = 1'b0;
      resetn       = 1'b1;
      #2 resetn    = 1'b0;
      #1;
      chk("rst.lock",          32'(lock),          32'd0);
      chk("rst.fec_out_valid", 32'(fec_out_valid), 32'd0);
      chk("rst.fec_out",       32'(fec_out),       32'd0);
      chk("rst.pilot_err_cnt", 32'(pilot_err_cnt), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk) resetn = 1'b1;

      // Lock acquisition
      send_mb("acq1", FA, TAIL_OK, 32, -1, 0, 1'b0, 1'b0, FA, xerr(0));
      send_mb("acq2", FA, TAIL_OK, 32, -1, 0, 1'b0, 1'b0, FA, xerr(0));
      send_mb("acq3", FA, TAIL_OK, 32, -1, 0, 1'b0, 1'b0, FA, xerr(0));
      send_mb("acq4", FA, TAIL_OK, 32, -1, 0, 1'b1, 1'b1, FA, xerr(0));

      // Pilot errors while locked
      send_mb("pil1",  FB, TAIL_PILOT, 32, -1, 0, 1'b0, 1'b1, FA, xerr(1));
      send_mb("clnB",  FB, TAIL_OK,    32, -1, 0, 1'b1, 1'b1, FB, xerr(1));
      send_mb("pil2a", FA, TAIL_PILOT, 32, -1, 0, 1'b0, 1'b1, FB, xerr(2));
      send_mb("pil2b", FA, TAIL_PILOT, 32, -1, 0, 1'b0, 1'b0, FB, xerr(3));

      // Relock, then invalid header at k=5
      send_mb("rl1", FA, TAIL_OK, 32, -1, 0, 1'b0, 1'b0, FA, xerr(3));
      send_mb("rl2", FA, TAIL_OK, 32, -1, 0, 1'b0, 1'b0, FA, xerr(3));
      send_mb("rl3", FA, TAIL_OK, 32, -1, 0, 1'b0, 1'b0, FA, xerr(3));
      send_mb("rl4", FA, TAIL_OK, 32, -1, 0, 1'b1, 1'b1, FA, xerr(3));
      send_mb("inv", FB, TAIL_OK, 32, 5,  0, 1'b0, 1'b1, FA, xerr(4));
      send_mb("aft", FA, TAIL_OK, 32, -1, 0, 1'b1, 1'b1, FA, xerr(4));

      // Short multiblocks then realignment
      send_mb("sh1", FC, TAIL_OK, 21, -1, 0, 1'b0, 1'b1, FA, xerr(5));
      send_mb("sh2", FC, TAIL_OK, 21, -1, 0, 1'b0, 1'b0, FA, xerr(6));
      send_mb("ra1", FC, TAIL_OK, 32, -1, 0, 1'b0, 1'b0, FC, xerr(6));
      send_mb("ra2", FC, TAIL_OK, 32, -1, 0, 1'b0, 1'b0, FC, xerr(6));
      send_mb("ra3", FC, TAIL_OK, 32, -1, 0, 1'b0, 1'b0, FC, xerr(6));
      send_mb("ra4", FC, TAIL_OK, 32, -1, 0, 1'b1, 1'b1, FC, xerr(6));

      // 33-block multiblock overruns the counter
      send_mb("ovr", FA, TAIL_OK, 33, -1, 0, 1'b0, 1'b1, FC, xerr(7));
      send_mb("pov", FC, TAIL_OK, 32, -1, 0, 1'b1, 1'b1, FC, xerr(7));

      // Drop lock, then reacquire with 3-cycle gaps between blocks
      send_mb("dl1", FA, TAIL_PILOT, 32, -1, 0, 1'b0, 1'b1, FC, xerr(8));
      send_mb("dl2", FA, TAIL_PILOT, 32, -1, 0, 1'b0, 1'b0, FC, xerr(9));
      send_mb("gp1", FD, TAIL_OK, 32, -1, 3, 1'b0, 1'b0, FD, xerr(9));
      send_mb("gp2", FD, TAIL_OK, 32, -1, 3, 1'b0, 1'b0, FD, xerr(9));
      send_mb("gp3", FD, TAIL_OK, 32, -1, 3, 1'b0, 1'b0, FD, xerr(9));
      send_mb("gp4", FD, TAIL_OK, 32, -1, 3, 1'b1, 1'b1, FD, xerr(9));

      // Reset mid-multiblock while locked
      ebits = {FE, TAIL_OK};
      for (int k = 0; k < 10; k++) blk(ebits[31 - k] ? 2'b10 : 2'b01, 1'b0);
      #2 resetn = 1'b0;
      #1;
      chk("mrst.lock",          32'(lock),          32'd0);
      chk("mrst.fec_out_valid", 32'(fec_out_valid), 32'd0);
      chk("mrst.fec_out",       32'(fec_out),       32'd0);
      chk("mrst.header_err",    32'(header_err),    32'd0);
      chk("mrst.pilot_err_cnt", 32'(pilot_err_cnt), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) resetn = 1'b1;
      send_mb("pr1", FE, TAIL_OK, 32, -1, 0, 1'b0, 1'b0, FE, xerr(0));
      send_mb("pr2", FE, TAIL_OK, 32, -1, 0, 1'b0, 1'b0, FE, xerr(0));
      send_mb("pr3", FE, TAIL_OK, 32, -1, 0, 1'b0, 1'b0, FE, xerr(0));
      send_mb("pr4", FE, TAIL_OK, 32, -1, 0, 1'b1, 1'b1, FE, xerr(0));

      repeat (3) @(negedge clk);
      chk("total.fec_out_valid_pulses", 32'(v_pulses), 32'(exp_v_pulses));
      chk("total.header_err_pulses",    32'(e_pulses), 32'(exp_e_pulses));
      chk("sb.queue_size",              32'(sbq.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
